// File: rtl/key_debounce.sv
// Key/switch conditioner: two-flop synchronizer, stability-count debounce FSM,
// registered level plus single-cycle press/release/long-press pulses and a saturating press count.
module key_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int LONG_CYCLES   = 16,
   parameter int CNT_W         = 8
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             a_in,
   output logic             level_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             long_pulse,
   output logic [CNT_W-1:0] press_count
);

   localparam int SW = $clog2(STABLE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0]    HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_REL     = 3'd0,
      ST_PWAIT   = 3'd1,
      ST_PRESSED = 3'd2,
      ST_HELD    = 3'd3,
      ST_RWAIT   = 3'd4
   } state_t;

   logic             r_s1;
   logic             r_s2;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [SW-1:0]    r_stab;
   logic [SW-1:0]    w_stab_nxt;
   logic [HW-1:0]    r_hold;
   logic [HW-1:0]    w_hold_nxt;
   logic             r_from_held;
   logic             w_from_held_nxt;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   logic             r_long;
   logic [CNT_W-1:0] r_count;
   logic             w_level_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic             w_long_nxt;
   logic [CNT_W-1:0] w_count_nxt;

   // Two-flop synchronizer for the asynchronous key input.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= a_in;
         r_s2 <= r_s1;
      end
   end

   // FSM state, stability counter, hold counter and release origin.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_REL;
         r_stab      <= '0;
         r_hold      <= '0;
         r_from_held <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_stab      <= w_stab_nxt;
         r_hold      <= w_hold_nxt;
         r_from_held <= w_from_held_nxt;
      end
   end

   // Next-state logic; a release sample always wins over the long-press check.
   always_comb begin
      w_state_nxt     = r_state;
      w_stab_nxt      = r_stab;
      w_hold_nxt      = r_hold;
      w_from_held_nxt = r_from_held;
      case (r_state)
         ST_REL: begin
            if (r_s2) begin
               w_state_nxt = ST_PWAIT;
               w_stab_nxt  = SW'(1);
            end else begin
               w_stab_nxt  = '0;
            end
         end
         ST_PWAIT: begin
            if (!r_s2) begin
               w_state_nxt = ST_REL;
               w_stab_nxt  = '0;
            end else if (r_stab == STAB_LAST) begin
               w_state_nxt = ST_PRESSED;
               w_stab_nxt  = '0;
               w_hold_nxt  = '0;
            end else begin
               w_stab_nxt  = r_stab + SW'(1);
            end
         end
         ST_PRESSED: begin
            if (!r_s2) begin
               w_state_nxt     = ST_RWAIT;
               w_stab_nxt      = SW'(1);
               w_from_held_nxt = 1'b0;
            end else if (r_hold == HOLD_LAST) begin
               w_state_nxt     = ST_HELD;
            end else begin
               w_hold_nxt      = r_hold + HW'(1);
            end
         end
         ST_HELD: begin
            if (!r_s2) begin
               w_state_nxt     = ST_RWAIT;
               w_stab_nxt      = SW'(1);
               w_from_held_nxt = 1'b1;
            end else begin
               w_state_nxt     = ST_HELD;
            end
         end
         ST_RWAIT: begin
            if (r_s2) begin
               w_state_nxt = r_from_held ? ST_HELD : ST_PRESSED;
               w_stab_nxt  = '0;
            end else if (r_stab == STAB_LAST) begin
               w_state_nxt = ST_REL;
               w_stab_nxt  = '0;
               w_hold_nxt  = '0;
            end else begin
               w_stab_nxt  = r_stab + SW'(1);
            end
         end
         default: begin
            w_state_nxt     = ST_REL;
            w_stab_nxt      = '0;
            w_hold_nxt      = '0;
            w_from_held_nxt = 1'b0;
         end
      endcase
   end

   // Output decode from the transition being taken this cycle.
   always_comb begin
      w_rise_nxt  = (r_state == ST_PWAIT)   &&  r_s2 && (r_stab == STAB_LAST);
      w_fall_nxt  = (r_state == ST_RWAIT)   && !r_s2 && (r_stab == STAB_LAST);
      w_long_nxt  = (r_state == ST_PRESSED) &&  r_s2 && (r_hold == HOLD_LAST);
      w_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_HELD) ||
                    (w_state_nxt == ST_RWAIT);
      if (w_rise_nxt && (r_count != CNT_MAX)) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Registered outputs.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_long  <= 1'b0;
         r_count <= '0;
      end else begin
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_long  <= w_long_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign level_out   = r_level;
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign long_pulse  = r_long;
   assign press_count = r_count;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts pulse events,
// a negedge monitor pops and compares them against what the DUT emits.
module tb_key_debounce;

   localparam int STABLE = 4;
   localparam int LONG   = 16;
   localparam int CW     = 2;

   logic          ck    = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_in  = 1'b1;
   logic          level_out;
   logic          rise_pulse;
   logic          fall_pulse;
   logic          long_pulse;
   logic [CW-1:0] press_count;

   key_debounce #(.STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .CNT_W(CW)) dut (
      .ck(ck), .rst_n(rst_n), .a_in(a_in),
      .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .long_pulse(long_pulse), .press_count(press_count)
   );

   always #5 ck = ~ck;

   typedef struct {int kind; int cyc; int cnt;} ev_t;   // kind: 0 rise, 1 fall, 2 long
   ev_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   // Reference model: accepted level flips after STABLE consecutive differing synced samples.
   int hist[2] = '{0, 0};
   int m_lvl = 0, run = 0, hcnt = 0, mcnt = 0, ldone = 0;
   initial forever begin
      int s;
      @(posedge ck or negedge rst_n);
      if (!rst_n) begin
         hist = '{0, 0}; m_lvl = 0; run = 0; hcnt = 0; mcnt = 0; ldone = 0;
         exp_q.delete();
      end else begin
         cyc++;
         s = hist[1];
         hist[1] = hist[0];
         hist[0] = int'(a_in);
         if (m_lvl == 1 && run == 0 && s == 1 && ldone == 0) begin
            hcnt++;
            if (hcnt == LONG) begin
               ldone = 1;
               exp_q.push_back('{2, cyc, mcnt});
            end
         end
         if (s != m_lvl) begin
            run++;
            if (run == STABLE) begin
               m_lvl = s;
               run = 0;
               if (s == 1) begin
                  if (mcnt < (1 << CW) - 1) mcnt++;
                  hcnt = 0;
                  ldone = 0;
                  exp_q.push_back('{0, cyc, mcnt});
               end else begin
                  exp_q.push_back('{1, cyc, mcnt});
               end
            end
         end else begin
            run = 0;
         end
      end
   end

   // Monitor: compare level/count each cycle and match every pulse against the queue.
   initial forever begin
      int k;
      ev_t e;
      @(negedge ck);
      chk("level", int'(level_out), m_lvl);
      chk("count", int'(press_count), mcnt);
      if (rise_pulse || fall_pulse || long_pulse) begin
         k = rise_pulse ? 0 : (fall_pulse ? 1 : 2);
         chk("one_pulse", int'(rise_pulse) + int'(fall_pulse) + int'(long_pulse), 1);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse_kind", k, -1);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", k, e.kind);
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_count", int'(press_count), e.cnt);
         end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         chk("missing_pulse_kind", -1, e.kind);
      end
   end

   task automatic hold_in(input logic v, input int n);
      a_in = v;
      repeat (n) @(negedge ck);
   endtask

   initial begin
      int edges;
      int saved;
      // Reset with key held: outputs zero before any clock edge.
      #2;
      chk("rst_level", int'(level_out), 0);
      chk("rst_pulses", int'(rise_pulse) + int'(fall_pulse) + int'(long_pulse), 0);
      chk("rst_count", int'(press_count), 0);
      @(negedge ck);
      @(negedge ck);
      rst_n = 1'b1;
      edges = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge ck);
         #1;
         if (level_out) begin
            edges = i;
            break;
         end
      end
      chk("press_latency_edges", edges, 6);
      chk("first_press_count", int'(press_count), 1);
      @(negedge ck);

      // Glitch rejection.
      hold_in(1'b0, 20);
      saved = int'(press_count);
      hold_in(1'b1, 3);
      hold_in(1'b0, 12);
      chk("glitch_level", int'(level_out), 0);
      chk("glitch_count", int'(press_count), saved);

      // Long press then release.
      hold_in(1'b1, 40);
      hold_in(1'b0, 20);

      // Release bounce while pressed, then clean release.
      hold_in(1'b1, 10);
      hold_in(1'b0, 2);
      hold_in(1'b1, 30);
      chk("bounce_level", int'(level_out), 1);
      hold_in(1'b0, 20);

      // Clean presses to reach and hold counter saturation.
      for (int i = 0; i < 5; i++) begin
         hold_in(1'b1, 10);
         hold_in(1'b0, 10);
      end
      chk("saturated_count", int'(press_count), 3);

      // Random bouncing segments.
      for (int i = 0; i < 60; i++) begin
         hold_in(1'($urandom_range(0, 1)), $urandom_range(1, 24));
      end
      hold_in(1'b0, 20);

      // Asynchronous reset while in HELD, key kept down through release.
      hold_in(1'b1, 30);
      chk("held_level", int'(level_out), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_level", int'(level_out), 0);
      chk("async_rst_fall", int'(fall_pulse), 0);
      chk("async_rst_count", int'(press_count), 0);
      @(negedge ck);
      rst_n = 1'b1;
      hold_in(1'b1, 15);
      chk("repress_count", int'(press_count), 1);
      hold_in(1'b0, 20);

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
